// File: rtl/hc_pkg.sv
// Shared types for the hc comparator scheduler: operand width, operand type
// and the scheduler state encoding.
package hc_pkg;
  localparam int TS_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } hc_sched_state_t;

  typedef logic signed [TS_W-1:0] ts_t;
endpackage

// File: rtl/hc_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr,
// wrapping modulo N, returned as one-hot and as an index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/hc_sched.sv
// Round-robin scheduler sharing one hc comparator among N requesters.
// Handshake: a requester holds req (and stable operands) until done pulses.
module hc_sched
  import hc_pkg::*;
#(
  parameter int N      = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*TS_W-1:0]    ts1_in,
  input  logic [N*TS_W-1:0]    ts2_in,
  output logic [N-1:0]         grant,
  output logic                 done,
  output logic                 result,
  output logic [N-1:0]         last_out,
  output ts_t                  hc_ts1,
  output ts_t                  hc_ts2,
  input  logic                 hc_out,
  output hc_sched_state_t      dbg_state
);
  localparam int IW = $clog2(N);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  hc_sched_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            done_q, done_d;
  logic            result_q, result_d;
  logic [N-1:0]    last_q, last_d;
  ts_t             ts1_q, ts1_d;
  ts_t             ts2_q, ts2_d;

  logic [N-1:0]    arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    done_d   = 1'b0;
    result_d = result_q;
    last_d   = last_q;
    ts1_d    = ts1_q;
    ts2_d    = ts2_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = DRIVE;
          grant_d = arb_gnt;
          ptr_d   = arb_idx;
          cnt_d   = '0;
          for (int i = 0; i < N; i++) begin
            if (arb_gnt[i]) begin
              ts1_d = ts1_in[i*TS_W +: TS_W];
              ts2_d = ts2_in[i*TS_W +: TS_W];
            end
          end
        end
      end
      DRIVE: begin
        // ptr_q still names the winner for the whole operation
        if (cnt_q == CW'(SETTLE - 1)) begin
          result_d      = hc_out;
          last_d[ptr_q] = hc_out;
          done_d        = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= IW'(N - 1);
      grant_q  <= '0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
      last_q   <= '0;
      ts1_q    <= '0;
      ts2_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      last_q   <= last_d;
      ts1_q    <= ts1_d;
      ts2_q    <= ts2_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign result    = result_q;
  assign last_out  = last_q;
  assign hc_ts1    = ts1_q;
  assign hc_ts2    = ts2_q;
  assign dbg_state = state_q;
endmodule
